dtw_score_grader: RTL and testbench



---
 rtl/dtw_pkg.sv | 24 ++
 rtl/dtw_grade_compare.sv | 27 ++
 rtl/dtw_score_grader.sv | 146 ++++++++++++++
 tb/tb_dtw_score_grader.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW core and its downstream grader.
package dtw_pkg;

    typedef enum logic [1:0] {
        GRADE_FAIL,
        GRADE_OK,
        GRADE_GOOD,
        GRADE_PERFECT
    } grade_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        GAP,
        GRADE,
        OUT
    } state_t;

    // DTW "no path" cost: 2^(w-4)-1, e.g. 63 for a 10-bit score.
    function automatic int unsigned sentinel(input int unsigned data_width);
        return (32'd1 << (data_width - 4)) - 32'd1;
    endfunction

endpackage

// File: rtl/dtw_grade_compare.sv
// Combinational mapping of an accumulated DTW cost to a 2-bit grade.
module dtw_grade_compare
    import dtw_pkg::*;
#(
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned T_PERFECT = 20,
    parameter int unsigned T_GOOD    = 60,
    parameter int unsigned T_OK      = 120
) (
    input  logic [ACC_W-1:0] acc,
    output grade_t           grade
);

    // Lower cost is better; thresholds are inclusive upper bounds.
    always_comb begin
        if (acc <= ACC_W'(T_PERFECT)) begin
            grade = GRADE_PERFECT;
        end else if (acc <= ACC_W'(T_GOOD)) begin
            grade = GRADE_GOOD;
        end else if (acc <= ACC_W'(T_OK)) begin
            grade = GRADE_OK;
        end else begin
            grade = GRADE_FAIL;
        end
    end

endmodule

// File: rtl/dtw_score_grader.sv
// Sequences N_RUNS DTW comparisons, accumulates their costs, and hands a
// grade to the host over a valid/ready handshake.
module dtw_score_grader
    import dtw_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned N_RUNS     = 4,
    parameter int unsigned T_PERFECT  = 20,
    parameter int unsigned T_GOOD     = 60,
    parameter int unsigned T_OK       = 120,
    parameter int unsigned TIMEOUT    = 4096,
    localparam int unsigned ACC_W     = DATA_WIDTH + $clog2(N_RUNS),
    localparam int unsigned CNT_W     = $clog2(N_RUNS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] score,
    input  logic                  done,
    output logic                  dtw_ready,
    output logic [ACC_W-1:0]      total,
    output logic [1:0]            grade,
    output logic                  grade_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      miss_cnt,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [DATA_WIDTH-1:0] SENTINEL = DATA_WIDTH'(sentinel(DATA_WIDTH));

    state_t                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        run_cnt_q, run_cnt_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [ACC_W-1:0]        total_d;
    logic [1:0]              grade_d;
    logic [CNT_W-1:0]        miss_cnt_d;
    logic                    timeout_err_d;
    logic                    run_end;
    logic [DATA_WIDTH-1:0]   run_score;
    grade_t                  cmp_grade;

    dtw_grade_compare #(
        .ACC_W     (ACC_W),
        .T_PERFECT (T_PERFECT),
        .T_GOOD    (T_GOOD),
        .T_OK      (T_OK)
    ) u_compare (
        .acc   (acc_q),
        .grade (cmp_grade)
    );

    // Next-state logic for the pass sequencer, counters and result registers.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        run_cnt_d     = run_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        total_d       = total;
        grade_d       = grade;
        miss_cnt_d    = miss_cnt;
        timeout_err_d = timeout_err;
        run_end       = 1'b0;
        run_score     = SENTINEL;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d         = '0;
                    run_cnt_d     = '0;
                    tmo_cnt_d     = '0;
                    miss_cnt_d    = '0;
                    timeout_err_d = 1'b0;
                    state_d       = RUN;
                end
            end
            RUN: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // A real done on the timeout cycle takes priority over the abort.
                run_end   = done || (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
                if (run_end) begin
                    run_score = done ? score : SENTINEL;
                    acc_d     = acc_q + ACC_W'(run_score);
                    if (!done || (score == SENTINEL)) begin
                        miss_cnt_d = miss_cnt + CNT_W'(1);
                    end
                    if (!done) begin
                        timeout_err_d = 1'b1;
                    end
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                    tmo_cnt_d = '0;
                    state_d   = (run_cnt_q == CNT_W'(N_RUNS - 1)) ? GRADE : GAP;
                end
            end
            // One cycle with ready low lets the DTW core fall back to its idle state.
            GAP: begin
                state_d = RUN;
            end
            GRADE: begin
                grade_d = cmp_grade;
                total_d = acc_q;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            run_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            total       <= '0;
            grade       <= '0;
            miss_cnt    <= '0;
            timeout_err <= 1'b0;
            dtw_ready   <= 1'b0;
            grade_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            run_cnt_q   <= run_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            total       <= total_d;
            grade       <= grade_d;
            miss_cnt    <= miss_cnt_d;
            timeout_err <= timeout_err_d;
            dtw_ready   <= (state_d == RUN);
            grade_valid <= (state_d == OUT);
            busy        <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_dtw_score_grader.sv
// Bench for dtw_score_grader: a default instance and a short-timeout instance
// share stimulus; sel chooses which one the driver follows and checks.
module tb_dtw_score_grader;

    localparam int ACC_W = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       done;
    logic       out_ready;
    logic [9:0] score;

    logic              dtw_ready_a, grade_valid_a, timeout_err_a, busy_a;
    logic [ACC_W-1:0]  total_a;
    logic [1:0]        grade_a;
    logic [2:0]        miss_cnt_a;
    logic              dtw_ready_b, grade_valid_b, timeout_err_b, busy_b;
    logic [ACC_W-1:0]  total_b;
    logic [1:0]        grade_b;
    logic [2:0]        miss_cnt_b;

    logic              sel;
    logic              o_ready, o_gv, o_terr, o_busy;
    logic [ACC_W-1:0]  o_total;
    logic [1:0]        o_grade;
    logic [2:0]        o_miss;

    assign o_ready = sel ? dtw_ready_b   : dtw_ready_a;
    assign o_gv    = sel ? grade_valid_b : grade_valid_a;
    assign o_terr  = sel ? timeout_err_b : timeout_err_a;
    assign o_busy  = sel ? busy_b        : busy_a;
    assign o_total = sel ? total_b       : total_a;
    assign o_grade = sel ? grade_b       : grade_a;
    assign o_miss  = sel ? miss_cnt_b    : miss_cnt_a;

    int n_tests, n_fail;
    int lat, gap_min, gap_max, hung;
    int prev_sel;

    dtw_score_grader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .score       (score),
        .done        (done),
        .dtw_ready   (dtw_ready_a),
        .total       (total_a),
        .grade       (grade_a),
        .grade_valid (grade_valid_a),
        .out_ready   (out_ready),
        .miss_cnt    (miss_cnt_a),
        .timeout_err (timeout_err_a),
        .busy        (busy_a)
    );

    dtw_score_grader #(.TIMEOUT(16)) dut_t (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .score       (score),
        .done        (done),
        .dtw_ready   (dtw_ready_b),
        .total       (total_b),
        .grade       (grade_b),
        .grade_valid (grade_valid_b),
        .out_ready   (out_ready),
        .miss_cnt    (miss_cnt_b),
        .timeout_err (timeout_err_b),
        .busy        (busy_b)
    );

    always #5 clk = ~clk;

    // Reference: a run whose done arrives within the timeout window counts its
    // real score; otherwise it costs 63 and is flagged as a timeout.
    function automatic void ref_pass(input int sc[4], input int dl[4], input int tmo,
                                     output int tot, output int miss, output int terr,
                                     output int gr);
        tot = 0; miss = 0; terr = 0;
        for (int i = 0; i < 4; i++) begin
            if (dl[i] <= tmo) begin
                tot += sc[i];
                if (sc[i] == 63) miss++;
            end else begin
                tot += 63;
                miss++;
                terr = 1;
            end
        end
        if (tot <= 20)       gr = 3;
        else if (tot <= 60)  gr = 2;
        else if (tot <= 120) gr = 1;
        else                 gr = 0;
    endfunction

    task automatic apply_reset();
        start = 0; done = 0; score = '0; out_ready = 1;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // Drives one pass; done for run r arrives in RUN cycle dl[r] unless the
    // selected DUT drops ready first. Records latency and GAP lengths.
    task automatic drive_pass(input int sc[4], input int dl[4], input int nruns);
        int w;
        hung = 0; gap_min = 99; gap_max = 0; lat = 0;
        w = 0;
        while (o_busy && w < 200) begin @(negedge clk); w++; end
        if (o_busy) begin hung = 1; return; end
        start = 1;
        @(negedge clk);
        start = 0;
        for (int r = 0; r < nruns; r++) begin
            int gap = 0;
            while (!o_ready && gap < 100) begin gap++; @(negedge clk); end
            if (!o_ready) begin hung = 1; return; end
            if (r > 0) begin
                if (gap < gap_min) gap_min = gap;
                if (gap > gap_max) gap_max = gap;
            end
            for (int k = 1; k < dl[r]; k++) begin
                @(negedge clk);
                if (!o_ready) break;
            end
            if (o_ready) begin
                done = 1; score = 10'(sc[r]);
                @(negedge clk);
                done = 0;
            end
        end
        if (nruns < 4) return;
        lat = 1;
        while (!o_gv && lat < 50) begin @(negedge clk); lat++; end
        if (!o_gv) hung = 1;
    endtask

    task automatic test_reset();
        sel = 0;
        apply_reset();
        n_tests++;
        if ({o_ready, o_busy, o_gv, o_terr} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000", {o_ready, o_busy, o_gv, o_terr});
        end
        n_tests++;
        if (o_total !== '0) begin
            n_fail++; $display("FAIL reset_total got %0d want 0", o_total);
        end
        n_tests++;
        if (o_grade !== 2'd0 || o_miss !== 3'd0) begin
            n_fail++; $display("FAIL reset_grade_miss got %0d/%0d want 0/0", o_grade, o_miss);
        end
    endtask

    task automatic test_basic();
        int sc[4]; int dl[4]; int et, em, ee, eg;
        sel = 0;
        sc = '{3, 5, 2, 4}; dl = '{20, 20, 20, 20};
        ref_pass(sc, dl, 4096, et, em, ee, eg);
        drive_pass(sc, dl, 4);
        n_tests++;
        if (hung != 0) begin n_fail++; $display("FAIL basic_hang got %0d want 0", hung); end
        n_tests++;
        if (o_total !== 12'(et)) begin
            n_fail++; $display("FAIL basic_total got %0d want %0d", o_total, et);
        end
        n_tests++;
        if (o_grade !== 2'(eg) || o_miss !== 3'(em)) begin
            n_fail++;
            $display("FAIL basic_grade_miss got %0d/%0d want %0d/%0d", o_grade, o_miss, eg, em);
        end
        n_tests++;
        if (lat != 2) begin n_fail++; $display("FAIL basic_latency got %0d want 2", lat); end
        @(negedge clk);
        n_tests++;
        if (o_gv !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_one_cycle_valid got %b/%b want 0/0", o_gv, o_busy);
        end
    endtask

    task automatic test_t_ok_boundary();
        int sc[4]; int dl[4]; int et, em, ee, eg;
        sel = 0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin sc[j] = 30; dl[j] = 4; end
            if (i == 1) sc[3] = 31;
            ref_pass(sc, dl, 4096, et, em, ee, eg);
            drive_pass(sc, dl, 4);
            n_tests++;
            if (hung != 0 || o_total !== 12'(et) || o_grade !== 2'(eg)) begin
                n_fail++;
                $display("FAIL t_ok_%0d got total %0d grade %0d want %0d %0d (hang %0d)",
                         i, o_total, o_grade, et, eg, hung);
            end
        end
    endtask

    task automatic test_sentinel();
        int sc[4]; int dl[4]; int et, em, ee, eg;
        sel = 0;
        sc = '{63, 10, 63, 0}; dl = '{3, 3, 3, 3};
        ref_pass(sc, dl, 4096, et, em, ee, eg);
        drive_pass(sc, dl, 4);
        n_tests++;
        if (hung != 0 || o_total !== 12'(et) || o_grade !== 2'(eg)) begin
            n_fail++;
            $display("FAIL sentinel_total got %0d/%0d want %0d/%0d", o_total, o_grade, et, eg);
        end
        n_tests++;
        if (o_miss !== 3'(em) || o_terr !== 1'(ee)) begin
            n_fail++;
            $display("FAIL sentinel_miss got %0d/%b want %0d/%0d", o_miss, o_terr, em, ee);
        end
        n_tests++;
        if (gap_min != 1 || gap_max != 1) begin
            n_fail++; $display("FAIL sentinel_gap got %0d..%0d want 1..1", gap_min, gap_max);
        end
    endtask

    task automatic test_timeout();
        int sc[4]; int dl[4]; int et, em, ee, eg;
        sel = 1;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            sc = '{1, 1, 1, 1}; dl = '{2, 1000, 2, 2};
            if (i == 1) begin sc[1] = 5; dl[1] = 16; end
            ref_pass(sc, dl, 16, et, em, ee, eg);
            drive_pass(sc, dl, 4);
            n_tests++;
            if (hung != 0 || o_total !== 12'(et) || o_grade !== 2'(eg)) begin
                n_fail++;
                $display("FAIL timeout_%0d_total got %0d/%0d want %0d/%0d",
                         i, o_total, o_grade, et, eg);
            end
            n_tests++;
            if (o_miss !== 3'(em) || o_terr !== 1'(ee)) begin
                n_fail++;
                $display("FAIL timeout_%0d_flags got %0d/%b want %0d/%0d",
                         i, o_miss, o_terr, em, ee);
            end
        end
    endtask

    task automatic test_backpressure();
        int sc[4]; int dl[4]; int et, em, ee, eg; int bad;
        sel = 0;
        apply_reset();
        out_ready = 0;
        sc = '{40, 0, 7, 12}; dl = '{5, 2, 9, 3};
        ref_pass(sc, dl, 4096, et, em, ee, eg);
        drive_pass(sc, dl, 4);
        n_tests++;
        if (hung != 0 || o_total !== 12'(et)) begin
            n_fail++; $display("FAIL bp_total got %0d want %0d", o_total, et);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 2 || i == 5);
            @(negedge clk);
            if (o_gv !== 1'b1 || o_total !== 12'(et) || o_grade !== 2'(eg)) bad++;
        end
        start = 0;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad);
        end
        out_ready = 1;
        @(negedge clk);
        n_tests++;
        if (o_gv !== 1'b0 || o_busy !== 1'b0 || o_total !== 12'(et)) begin
            n_fail++;
            $display("FAIL bp_release got gv %b busy %b total %0d want 0 0 %0d",
                     o_gv, o_busy, o_total, et);
        end
    endtask

    task automatic test_reset_mid();
        int sc[4]; int dl[4]; int et, em, ee, eg;
        sel = 0;
        sc = '{50, 50, 50, 50}; dl = '{4, 4, 4, 4};
        drive_pass(sc, dl, 2);
        rst_n = 0;
        #1;
        n_tests++;
        if ({o_ready, o_busy, o_gv} !== 3'b0 || o_total !== '0) begin
            n_fail++;
            $display("FAIL midreset got rdy/busy/gv %b total %0d want 000 0",
                     {o_ready, o_busy, o_gv}, o_total);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        sc = '{1, 1, 1, 1}; dl = '{3, 3, 3, 3};
        ref_pass(sc, dl, 4096, et, em, ee, eg);
        drive_pass(sc, dl, 4);
        n_tests++;
        if (hung != 0 || o_total !== 12'(et) || o_grade !== 2'(eg)) begin
            n_fail++;
            $display("FAIL midreset_fresh got %0d/%0d want %0d/%0d", o_total, o_grade, et, eg);
        end
    endtask

    task automatic test_random();
        int sc[4]; int dl[4]; int et, em, ee, eg;
        for (int p = 0; p < 16; p++) begin
            sel = 1'($urandom_range(0, 1));
            if (sel || int'(sel) != prev_sel) apply_reset();
            prev_sel = int'(sel);
            for (int j = 0; j < 4; j++) begin
                sc[j] = ($urandom_range(0, 3) == 0) ? 63 : $urandom_range(0, (p < 8) ? 40 : 1023);
                dl[j] = sel ? $urandom_range(1, 20) : $urandom_range(1, 25);
            end
            ref_pass(sc, dl, sel ? 16 : 4096, et, em, ee, eg);
            drive_pass(sc, dl, 4);
            n_tests++;
            if (hung != 0 || lat != 2 || o_total !== 12'(et) || o_grade !== 2'(eg)) begin
                n_fail++;
                $display("FAIL rand_%0d got total %0d grade %0d lat %0d want %0d %0d 2",
                         p, o_total, o_grade, lat, et, eg);
            end
            n_tests++;
            if (o_miss !== 3'(em) || o_terr !== 1'(ee)) begin
                n_fail++;
                $display("FAIL rand_%0d_flags got %0d/%b want %0d/%0d", p, o_miss, o_terr, em, ee);
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; sel = 0; prev_sel = 0;
        rst_n = 0; start = 0; done = 0; score = '0; out_ready = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_t_ok_boundary();
        test_sentinel();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

endmodule
